// File: rtl/alu_result_tx_ctrl.sv
// alu_result_tx_ctrl: serializes each captured ALU result into bytes (LSB first) for a UART TX
// Ports:
//   CLK, RST       rising-edge clock, synchronous active-high reset
//   ALU_OUT        ALU result, qualified by the one-cycle OUT_VALID strobe
//   TX_BUSY        UART TX is serializing a byte
//   TX_P_DATA      byte presented to the UART TX, held from issue until its busy window ends
//   TX_D_VALID     one-cycle request to transmit TX_P_DATA
//   CTRL_BUSY      high while a frame is in flight or a result is pending
//   OVERFLOW       sticky: a result was dropped because active and pending were both occupied
// Define ALU_TX_CHECKSUM_EN to append an XOR-of-data-bytes checksum byte to every frame.
module alu_result_tx_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             OUT_VALID,
  input  logic             TX_BUSY,
  output logic [7:0]       TX_P_DATA,
  output logic             TX_D_VALID,
  output logic             CTRL_BUSY,
  output logic             OVERFLOW
);
  localparam int NB = WIDTH / 8;
`ifdef ALU_TX_CHECKSUM_EN
  localparam int FB = NB + 1;
`else
  localparam int FB = NB;
`endif
  localparam int CW = $clog2(FB + 1);
  localparam logic [CW-1:0] LAST = CW'(FB - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic [7:0]       byte_sel;
`ifdef ALU_TX_CHECKSUM_EN
  logic [7:0]       csum;
`endif
  always_comb begin
    byte_sel = '0;
`ifdef ALU_TX_CHECKSUM_EN
    csum = '0;
    for (int i = 0; i < NB; i++) csum = csum ^ active[8*i +: 8];
    if (cnt == CW'(NB)) byte_sel = csum;
`endif
    for (int i = 0; i < NB; i++) if (cnt == CW'(i)) byte_sel = active[8*i +: 8];
  end
  assign CTRL_BUSY = (state != IDLE) | pend_full;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      active     <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      TX_D_VALID <= 1'b0;
      // results arriving mid-frame go to the single pending slot, or are dropped if it is taken
      if (OUT_VALID && state != IDLE) begin
        if (pend_full) OVERFLOW <= 1'b1;
        else begin
          pend      <= ALU_OUT;
          pend_full <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          // the pending word is older than anything on ALU_OUT, so it starts first
          if (pend_full) begin
            active <= pend;
            state  <= ISSUE;
            if (OUT_VALID) pend <= ALU_OUT;
            else pend_full <= 1'b0;
          end else if (OUT_VALID) begin
            active <= ALU_OUT;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!TX_BUSY) begin
            TX_P_DATA  <= byte_sel;
            TX_D_VALID <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: if (TX_BUSY) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// tb_alu_result_tx_ctrl: scoreboard bench with a UART TX busy model and word-level reference model
module tb_alu_result_tx_ctrl;
  localparam int WIDTH = 16;
  localparam int NB = WIDTH / 8;
`ifdef ALU_TX_CHECKSUM_EN
  localparam int FB = NB + 1;
`else
  localparam int FB = NB;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_valid = 1'b0;
  logic [WIDTH-1:0] alu_out = '0;
  logic f_busy = 1'b0;
  logic m_busy = 1'b0;
  logic tx_busy;
  logic [7:0] tx_p_data;
  logic tx_d_valid, ctrl_busy, overflow;
  logic [7:0] expq[$];
  int held = 0, retired = 0, ended = 0;
  int checks = 0, errors = 0, to_req = 0, to_seen = 0;
  int busy_len = 10, bcnt = 0, sent = 0;
  bit m_ovf = 1'b0, prev_v = 1'b0, rst_prev = 1'b0;

  assign tx_busy = m_busy | f_busy;
  always #5 clk = ~clk;

  alu_result_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(clk), .RST(rst), .ALU_OUT(alu_out), .OUT_VALID(out_valid), .TX_BUSY(tx_busy),
    .TX_P_DATA(tx_p_data), .TX_D_VALID(tx_d_valid), .CTRL_BUSY(ctrl_busy), .OVERFLOW(overflow)
  );

  // reference model: words held (active + pending) at most two; a third is dropped
  always @(posedge clk) begin
    if (rst) begin
      expq.delete();
      held = 0;
      m_ovf = 1'b0;
      retired = ended;
    end else begin
      if (out_valid) begin
        if (held < 2) begin
          logic [7:0] cs;
          cs = '0;
          held++;
          for (int b = 0; b < NB; b++) begin
            expq.push_back(alu_out[8*b +: 8]);
            cs = cs ^ alu_out[8*b +: 8];
          end
          if (FB > NB) expq.push_back(cs);
        end else m_ovf = 1'b1;
      end
      while (retired != ended) begin
        if (held > 0) held--;
        retired++;
      end
    end
  end

  // monitor plus UART TX model: busy for busy_len cycles (random when 0) after each request
  always @(negedge clk) begin
    logic b0;
    logic [7:0] e;
    b0 = tx_busy;
    if (to_req != to_seen) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=not_idle exp=idle");
      to_seen = to_req;
    end
    checks++;
    if (ctrl_busy !== (held != 0)) begin
      errors++;
      $display("FAIL ctrl_busy got=%0b exp=%0b t=%0t", ctrl_busy, held != 0, $time);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow got=%0b exp=%0b t=%0t", overflow, m_ovf, $time);
    end
    if (rst_prev) begin
      checks++;
      if (tx_d_valid !== 1'b0 || tx_p_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs got valid=%0b data=%02h exp valid=0 data=00", tx_d_valid, tx_p_data);
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      bcnt = 0;
      sent = 0;
    end else begin
      if (m_busy) begin
        bcnt--;
        if (bcnt == 0) begin
          m_busy = 1'b0;
          if (sent % FB == 0) ended++;
        end
      end
      if (tx_d_valid) begin
        checks++;
        if (prev_v || b0) begin
          errors++;
          $display("FAIL valid_protocol got prev_valid=%0b busy=%0b exp prev_valid=0 busy=0", prev_v, b0);
        end
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got=%02h exp=none t=%0t", tx_p_data, $time);
        end else begin
          e = expq.pop_front();
          if (tx_p_data !== e) begin
            errors++;
            $display("FAIL tx_byte got=%02h exp=%02h t=%0t", tx_p_data, e, $time);
          end
        end
        m_busy = 1'b1;
        bcnt = (busy_len == 0) ? int'($urandom_range(1, 8)) : busy_len;
        sent++;
      end
    end
    prev_v = tx_d_valid;
    rst_prev = rst;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    out_valid = 1'b1;
    alu_out = w;
    cyc(1);
    out_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (held == 0 && expq.size() == 0 && !tx_busy) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!ok) to_req++;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    send(16'h3664);
    drain();
    f_busy = 1'b1;
    cyc(3);
    send(16'hA55A);
    cyc(17);
    f_busy = 1'b0;
    drain();
    send(16'h1234);
    cyc(4);
    send(16'hABCD);
    drain();
    out_valid = 1'b1;
    alu_out = 16'h0001;
    cyc(1);
    alu_out = 16'h0002;
    cyc(1);
    out_valid = 1'b0;
    drain();
    send(16'h1234);
    cyc(3);
    send(16'hABCD);
    cyc(2);
    send(16'h5555);
    drain();
    cyc(5);
    send(16'hBEEF);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (tx_d_valid) begin
          seen = 1'b1;
          break;
        end
        cyc(1);
      end
      if (!seen) to_req++;
    end
    cyc(1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(20);
    send(16'h00FF);
    drain();
    busy_len = 0;
    for (int i = 0; i < 800; i++) begin
      out_valid = ($urandom_range(0, 5) == 0);
      alu_out = WIDTH'($urandom);
      cyc(1);
    end
    out_valid = 1'b0;
    drain();
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
